// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the digit-rotation helper for the seven-segment scan multiplexer.
package seven_seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 32;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    // Circular search for the next set bit after idx within an n-bit mask.
    // Starting from n-1 yields the lowest set bit. Returns idx when the mask is empty.
    function automatic int unsigned next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                                 input int unsigned           idx,
                                                 input int unsigned           n);
        int unsigned result;
        int unsigned j;
        logic        found;
        result = idx;
        found  = 1'b0;
        for (int unsigned k = 1; k <= MAX_DIGITS; k++) begin
            if (k <= n) begin
                j = idx + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!found && (((mask >> j) & 32'd1) != 32'd0)) begin
                    result = j;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-slot cycle counter: flags the last blanking cycle and the last cycle of the slot.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIV   = 20000,
    parameter int unsigned BLANK = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_done,
    output logic slot_end
);

    localparam int unsigned CBITS = $clog2(DIV);

    logic [CBITS-1:0] cnt_q, cnt_d;

    assign blank_done = (cnt_q == CBITS'(BLANK - 1));
    assign slot_end   = (cnt_q == CBITS'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || slot_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Round-robin seven-segment scanner with per-slot blanking and frame-aligned input snapshot.
module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIV            = 20000,
    parameter int unsigned BLANK          = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [SEG_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]            segment,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic                        sig,
    output logic                        frame
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow_q, shadow_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic sig_q, sig_d;
    logic frame_q, frame_d;

    logic run;
    logic tmr_clear;
    logic blank_done;
    logic slot_end;
    logic [IDX_W-1:0] lowest_idx;
    logic [IDX_W-1:0] next_idx;

    seven_seg_slot_timer #(
        .DIV  (DIV),
        .BLANK(BLANK)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .blank_done(blank_done),
        .slot_end  (slot_end)
    );

    assign run        = en && (|digit_en);
    assign lowest_idx = IDX_W'(next_enabled(MAX_DIGITS'(digit_en), NUM_DIGITS - 1, NUM_DIGITS));
    assign next_idx   = IDX_W'(next_enabled(MAX_DIGITS'(digit_en), 32'(idx_q), NUM_DIGITS));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        sig_d     = 1'b0;
        frame_d   = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            StIdle: begin
                tmr_clear = 1'b1;
                if (run) begin
                    state_d  = StBlank;
                    idx_d    = lowest_idx;
                    shadow_d = digits_in;
                    sig_d    = 1'b1;
                    frame_d  = 1'b1;
                end
            end
            StBlank: begin
                if (!run) begin
                    state_d   = StIdle;
                    tmr_clear = 1'b1;
                end else if (blank_done) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (!run) begin
                    state_d   = StIdle;
                    tmr_clear = 1'b1;
                end else if (slot_end) begin
                    // Mask is sampled only here, so a mid-slot change never truncates a slot.
                    state_d = StBlank;
                    idx_d   = next_idx;
                    sig_d   = 1'b1;
                    if (next_idx == lowest_idx) begin
                        frame_d  = 1'b1;
                        shadow_d = digits_in;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // Output registers load from next-state so pins line up with the state they describe.
    always_comb begin
        an_d  = '0;
        seg_d = SEG_OFF;
        if (state_d == StShow) begin
            an_d[idx_d] = 1'b1;
            seg_d       = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= '0;
            sig_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            sig_q    <= sig_d;
            frame_q  <= frame_d;
        end
    end

    assign segment = seg_q ^ {SEG_W{SEG_ACTIVE_LOW}};
    assign anode   = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    assign sig     = sig_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: cycle scoreboard plus vector table and corner-case sequences.
module tb_seven_seg_scan_mux;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int BK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [27:0] digits_in = '0;
    logic [3:0]  digit_en = '0;

    logic [6:0] segment, segment_n;
    logic [3:0] anode, anode_n;
    logic       sig, frame, sig_n, frame_n;

    seven_seg_scan_mux #(
        .NUM_DIGITS    (ND),
        .DIV           (DV),
        .BLANK         (BK),
        .SEG_ACTIVE_LOW(1'b0),
        .AN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .digits_in(digits_in),
        .digit_en (digit_en),
        .segment  (segment),
        .anode    (anode),
        .sig      (sig),
        .frame    (frame)
    );

    seven_seg_scan_mux #(
        .NUM_DIGITS    (ND),
        .DIV           (DV),
        .BLANK         (BK),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut_n (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .digits_in(digits_in),
        .digit_en (digit_en),
        .segment  (segment_n),
        .anode    (anode_n),
        .sig      (sig_n),
        .frame    (frame_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       sig;
        logic       frame;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       sig;
        logic       frame;
    } vec_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i[1:0]]) return i;
        end
        return 0;
    endfunction

    function automatic int m_next(input logic [3:0] m, input int i);
        int j;
        for (int k = 1; k <= 4; k++) begin
            j = (i + k) % 4;
            if (m[j[1:0]]) return j;
        end
        return i;
    endfunction

    // Reference model: m_t is the position inside the current slot.
    bit          m_active = 1'b0;
    int          m_t = 0;
    int          m_idx = 0;
    logic [27:0] m_shadow = '0;
    exp_t        m_e;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_idx    = 0;
            m_shadow = '0;
            sb_q.delete();
        end else begin
            m_e = '0;
            if (!(en && digit_en != 4'h0)) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (!m_active) begin
                m_active  = 1'b1;
                m_t       = 0;
                m_idx     = m_lowest(digit_en);
                m_shadow  = digits_in;
                m_e.sig   = 1'b1;
                m_e.frame = 1'b1;
            end else begin
                m_t++;
                if (m_t == DV) begin
                    m_t     = 0;
                    m_idx   = m_next(digit_en, m_idx);
                    m_e.sig = 1'b1;
                    if (m_idx == m_lowest(digit_en)) begin
                        m_e.frame = 1'b1;
                        m_shadow  = digits_in;
                    end
                end
            end
            if (m_active && m_t >= BK) begin
                m_e.an  = 4'b0001 << m_idx;
                m_e.seg = m_shadow[m_idx*7 +: 7];
            end
            sb_q.push_back(m_e);
        end
    end

    exp_t c_e;
    initial forever begin
        @(negedge clk);
        if (rst_n && sb_q.size() > 0) begin
            c_e = sb_q.pop_front();
            chk("scoreboard", 32'({anode, segment, sig, frame}), 32'(c_e));
            chk("active_low_pins", 32'({anode_n, segment_n, sig_n, frame_n}),
                32'({~c_e.an, ~c_e.seg, c_e.sig, c_e.frame}));
        end
    end

    // Leaves the DUT idle with en=1 and the new mask applied; next negedge is cycle 0.
    task automatic start(input logic [3:0] mask);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en       = 1'b1;
        digit_en = mask;
    endtask

    task automatic run_table(input logic [3:0] mask, input int ncyc);
        start(mask);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].mask == mask && tbl[i].cyc == c) begin
                    chk($sformatf("table_m%b_c%0d", mask, c), 32'({anode, segment, sig, frame}),
                        32'({tbl[i].an, tbl[i].seg, tbl[i].sig, tbl[i].frame}));
                end
            end
        end
    endtask

    int ns, nf;

    initial begin
        tbl.push_back('{4'hF, 0, 4'b0000, 7'h00, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 1, 4'b0000, 7'h00, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 2, 4'b0001, 7'h7F, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 7, 4'b0001, 7'h7F, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 8, 4'b0000, 7'h00, 1'b1, 1'b0});
        tbl.push_back('{4'hF, 10, 4'b0010, 7'h14, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 18, 4'b0100, 7'h0C, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 26, 4'b1000, 7'h06, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 32, 4'b0000, 7'h00, 1'b1, 1'b1});
        tbl.push_back('{4'hF, 34, 4'b0001, 7'h7F, 1'b0, 1'b0});
        tbl.push_back('{4'b0101, 0, 4'b0000, 7'h00, 1'b1, 1'b1});
        tbl.push_back('{4'b0101, 2, 4'b0001, 7'h7F, 1'b0, 1'b0});
        tbl.push_back('{4'b0101, 8, 4'b0000, 7'h00, 1'b1, 1'b0});
        tbl.push_back('{4'b0101, 10, 4'b0100, 7'h0C, 1'b0, 1'b0});
        tbl.push_back('{4'b0101, 16, 4'b0000, 7'h00, 1'b1, 1'b1});
        tbl.push_back('{4'b0101, 18, 4'b0001, 7'h7F, 1'b0, 1'b0});

        #12;
        chk("reset_outputs", 32'({anode, segment, sig, frame}), 32'(0));
        chk("reset_pins_active_low", 32'({anode_n, segment_n, sig_n, frame_n}),
            32'({4'hF, 7'h7F, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        digits_in = 28'h0C3_0A7F;

        run_table(4'hF, 40);
        run_table(4'b0101, 24);

        // Input change mid-frame must not reach the pins until the next frame.
        start(4'hF);
        repeat (10) @(negedge clk);
        digits_in = 28'h123_4567;
        repeat (9) @(negedge clk);
        chk("shadow_hold_c18", 32'({anode, segment}), 32'({4'b0100, 7'h0C}));
        repeat (16) @(negedge clk);
        chk("shadow_reload_c34", 32'({anode, segment}), 32'({4'b0001, 7'h67}));

        // One-cycle en drop while showing digit 2 restarts at digit 0.
        repeat (16) @(negedge clk);
        chk("show_digit2_c50", 32'(anode), 32'(4'b0100));
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_idle", 32'({anode, segment, sig, frame}), 32'(0));
        en = 1'b1;
        @(negedge clk);
        chk("restart_pulse", 32'({anode, sig, frame}), 32'({4'b0000, 1'b1, 1'b1}));
        repeat (2) @(negedge clk);
        chk("restart_digit0", 32'({anode, segment}), 32'({4'b0001, 7'h67}));

        // Empty mask parks the scanner.
        digit_en = 4'h0;
        ns = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sig || frame) ns++;
        end
        chk("empty_mask_no_pulse", 32'(ns), 32'(0));
        chk("empty_mask_pins_n", 32'({anode_n, segment_n}), 32'({4'hF, 7'h7F}));

        // A single enabled digit pulses sig and frame every slot.
        start(4'b0100);
        ns = 0;
        nf = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (sig) ns++;
            if (frame) nf++;
        end
        chk("single_digit_sig", 32'(ns), 32'(4));
        chk("single_digit_frame", 32'(nf), 32'(4));

        // Disabling the shown digit mid-slot keeps it lit until the slot ends.
        start(4'b0101);
        repeat (4) @(negedge clk);
        digit_en = 4'b1010;
        repeat (2) @(negedge clk);
        chk("disabled_digit_held", 32'(anode), 32'(4'b0001));
        repeat (3) @(negedge clk);
        chk("mask_change_advance", 32'({anode, sig, frame}), 32'({4'b0000, 1'b1, 1'b1}));
        repeat (2) @(negedge clk);
        chk("mask_change_digit1", 32'(anode), 32'(4'b0010));

        // Asynchronous reset between clock edges while a digit is lit.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({anode, segment, sig, frame}), 32'(0));
        chk("async_reset_pins_n", 32'({anode_n, segment_n, sig_n, frame_n}),
            32'({4'hF, 7'h7F, 1'b0, 1'b0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start(4'hF);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
